// File: rtl/xf100_exu_dispatch.sv
// EXU dispatch: accepts decoded ops, blocks RAW/WAW hazards via a per-register scoreboard,
// and holds one issued op toward the ALU. Optional writeback bypass: XF100_DISP_WB_BYPASS_EN.
module xf100_exu_dispatch #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int ALU_INFO_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_i_valid,
  output logic                  disp_o_ready,
  input  logic                  disp_i_alu_op,
  input  logic [ALU_INFO_W-1:0] disp_i_alu_info,
  input  logic                  disp_i_rs1_en,
  input  logic                  disp_i_rs2_en,
  input  logic                  disp_i_rd_en,
  input  logic [RFIDX_W-1:0]    disp_i_rs1_idx,
  input  logic [RFIDX_W-1:0]    disp_i_rs2_idx,
  input  logic [RFIDX_W-1:0]    disp_i_rd_idx,
  output logic [RFIDX_W-1:0]    disp_o_rf_rs1_idx,
  output logic [RFIDX_W-1:0]    disp_o_rf_rs2_idx,
  input  logic [XLEN-1:0]       disp_i_rf_rs1_dat,
  input  logic [XLEN-1:0]       disp_i_rf_rs2_dat,
  output logic                  disp_o_alu_valid,
  input  logic                  disp_i_alu_ready,
  output logic [ALU_INFO_W-1:0] disp_o_alu_info,
  output logic [XLEN-1:0]       disp_o_alu_op1,
  output logic [XLEN-1:0]       disp_o_alu_op2,
  output logic                  disp_o_alu_rd_en,
  output logic [RFIDX_W-1:0]    disp_o_alu_rd_idx,
  input  logic                  disp_i_wb_valid,
  input  logic [RFIDX_W-1:0]    disp_i_wb_idx,
  input  logic [XLEN-1:0]       disp_i_wb_dat,
  output logic                  disp_o_illegal,
  output logic                  disp_o_busy
);
  localparam int NREG = 2 ** RFIDX_W;

  // x0 is hardwired clean, so only bits 1..NREG-1 are stored
  logic [NREG-1:1]       r_sb;
  logic [NREG-1:0]       w_sb;
  logic [NREG-1:1]       w_sb_set;
  logic [NREG-1:1]       w_sb_clr;
  logic                  w_haz_rs1;
  logic                  w_haz_rs2;
  logic                  w_haz_rd;
  logic                  w_hazard;
  logic                  w_accept;
  logic                  w_issue;
  logic [XLEN-1:0]       w_op1;
  logic [XLEN-1:0]       w_op2;
  logic                  r_alu_valid;
  logic                  r_alu_rd_en;
  logic                  r_illegal;
  logic [ALU_INFO_W-1:0] r_alu_info;
  logic [XLEN-1:0]       r_alu_op1;
  logic [XLEN-1:0]       r_alu_op2;
  logic [RFIDX_W-1:0]    r_alu_rd_idx;

  assign w_sb     = {r_sb, 1'b0};
  assign w_haz_rd = disp_i_rd_en & w_sb[disp_i_rd_idx];

`ifdef XF100_DISP_WB_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  assign w_byp1    = disp_i_wb_valid & (disp_i_wb_idx == disp_i_rs1_idx) & (disp_i_rs1_idx != '0);
  assign w_byp2    = disp_i_wb_valid & (disp_i_wb_idx == disp_i_rs2_idx) & (disp_i_rs2_idx != '0);
  assign w_haz_rs1 = disp_i_rs1_en & w_sb[disp_i_rs1_idx] & ~w_byp1;
  assign w_haz_rs2 = disp_i_rs2_en & w_sb[disp_i_rs2_idx] & ~w_byp2;
  assign w_op1     = !disp_i_rs1_en ? '0 : (w_byp1 ? disp_i_wb_dat : disp_i_rf_rs1_dat);
  assign w_op2     = !disp_i_rs2_en ? '0 : (w_byp2 ? disp_i_wb_dat : disp_i_rf_rs2_dat);
`else
  logic w_unused_wb_dat;

  assign w_unused_wb_dat = ^disp_i_wb_dat;
  assign w_haz_rs1       = disp_i_rs1_en & w_sb[disp_i_rs1_idx];
  assign w_haz_rs2       = disp_i_rs2_en & w_sb[disp_i_rs2_idx];
  assign w_op1           = disp_i_rs1_en ? disp_i_rf_rs1_dat : '0;
  assign w_op2           = disp_i_rs2_en ? disp_i_rf_rs2_dat : '0;
`endif

  assign w_hazard     = disp_i_valid & (w_haz_rs1 | w_haz_rs2 | w_haz_rd);
  assign disp_o_ready = ~w_hazard & (~r_alu_valid | disp_i_alu_ready);
  assign w_accept     = disp_i_valid & disp_o_ready;
  assign w_issue      = w_accept & disp_i_alu_op;

  // set has priority over a same-cycle writeback to the same register
  for (genvar gi = 1; gi < NREG; gi++) begin : g_sb
    assign w_sb_set[gi] = w_issue & disp_i_rd_en & (disp_i_rd_idx == RFIDX_W'(gi));
    assign w_sb_clr[gi] = disp_i_wb_valid & (disp_i_wb_idx == RFIDX_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb <= '0;
    end else begin
      r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_valid  <= 1'b0;
      r_alu_info   <= '0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_alu_rd_en  <= 1'b0;
      r_alu_rd_idx <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_illegal <= w_accept & ~disp_i_alu_op;
      if (w_issue) begin
        r_alu_valid  <= 1'b1;
        r_alu_info   <= disp_i_alu_info;
        r_alu_op1    <= w_op1;
        r_alu_op2    <= w_op2;
        r_alu_rd_en  <= disp_i_rd_en;
        r_alu_rd_idx <= disp_i_rd_idx;
      end else if (disp_i_alu_ready) begin
        r_alu_valid <= 1'b0;
      end
    end
  end

  assign disp_o_rf_rs1_idx = disp_i_rs1_idx;
  assign disp_o_rf_rs2_idx = disp_i_rs2_idx;
  assign disp_o_alu_valid  = r_alu_valid;
  assign disp_o_alu_info   = r_alu_info;
  assign disp_o_alu_op1    = r_alu_op1;
  assign disp_o_alu_op2    = r_alu_op2;
  assign disp_o_alu_rd_en  = r_alu_rd_en;
  assign disp_o_alu_rd_idx = r_alu_rd_idx;
  assign disp_o_illegal    = r_illegal;
  assign disp_o_busy       = (|r_sb) | r_alu_valid;

endmodule
